dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock and reset ports are named clk and reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder accepts the request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 is reserved and flagged as an error.
REQ-008 req_sign  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-009 req_addr  input  32  byte address; only bits [11:0] are used.
REQ-010 req_wdata  input  32  store data, right-aligned in bits [7:0], [15:0] or [31:0].
REQ-011 req_pc  input  32  PC of the issuing instruction; used only for the write log.
REQ-012 rsp_valid  output  1  response is present.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or had a reserved size.

Function
REQ-016 Storage SHALL be a 1024 x 32 word array indexed by req_addr[11:2], little-endian: byte lane n = bits [8n+7:8n].
REQ-017 States: IDLE, RD, WR, RSP; req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance occurs when req_valid=1 and req_ready=1; the block SHALL register all request fields at acceptance.
REQ-019 Error condition: size 11, or half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 On an error request: IDLE->RSP; rsp_err=1; rsp_rdata=0; memory is not modified.
REQ-021 On a load: IDLE->RD->RSP.
- In RD, the addressed word is read and registered.
- The selected lane is extended per req_sign.
- rsp_valid is first high in the second cycle after acceptance (N+2).
REQ-022 On a store: IDLE->RD->WR->RSP.
- In RD, the old word is read.
- In WR, the merged word is written: new byte/half placed in the lane given by addr[1:0]/addr[1], other lanes preserved.
- rsp_valid is first high at N+3.
REQ-023 In RSP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1; the state then goes to IDLE on the next edge.
- There is no back-to-back acceptance.
REQ-024 req_valid asserted outside IDLE SHALL be ignored; no request is queued.
REQ-025 Address bits [31:12] SHALL be ignored; addresses wrap modulo 4 KB.
REQ-026 rsp_valid SHALL be 0 in IDLE, RD and WR.

Reset
REQ-027 While reset=0 at a rising edge, the block SHALL:
- set state to IDLE;
- clear rsp_valid, rsp_err and rsp_rdata to 0;
- clear every memory word to 0;
- drive req_ready to 1 after release.
REQ-028 Reset asserted in RD or WR SHALL abort the operation; no response is issued, and the reset clear takes precedence over any pending write.

Configuration
REQ-029 Macro DMEM_WRITE_LOG_EN: when defined, each WR-state write SHALL print "@<req_pc hex>: *<byte address of word hex> <= <merged word hex>" once; when undefined, no print logic is compiled and behaviour is otherwise identical.

Verification
REQ-030 Word store then load: store addr 0x10 data 0xDEADBEEF, then load word addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid at N+3 for the store and N+2 for the load.
REQ-031 Byte merge: word 0x11223344 at 0x20; store byte 0xAA at 0x22 -> word reads 0x11AA3344; load byte 0x22 with sign=1 -> 0xFFFFFFAA; with sign=0 -> 0x000000AA.
REQ-032 Half: store half 0x8001 at 0x32 over 0 -> word reads 0x80010000; load half 0x32 with sign=1 -> 0xFFFF8001.
REQ-033 Errors: load half at 0x41 -> rsp_err=1 at N+1, rsp_rdata=0; store word at 0x42 -> rsp_err=1 and memory unchanged.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; a req_valid pulse during that time is not accepted.
REQ-035 Reset mid-store: assert reset in RD of a store to 0x50 -> no response; after release, 0x50 reads 0 and req_ready=1.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port 4 KB data memory behind a valid/ready request
// and response handshake. It handles byte/half/word loads with sign or zero
// extension and read-modify-write stores.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_size    store/load select, access size (11 reserved)
//   req_sign            sign-extend loads when 1
//   req_addr            byte address, bits [11:0] used
//   req_wdata           store data, right-aligned
//   req_pc              issuing PC, used only by the write log
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  extended load data, misaligned/reserved-size flag
//
// Optional feature: define DMEM_WRITE_LOG_EN to print every memory write.

module dmem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned DEPTH  = 1024;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t              state, state_next;
  logic                req_ready_n, rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0]   rsp_rdata_n;

  logic                we_q, sign_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, word_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                err_c, accept_c;
  logic [IDX_W-1:0]    idx_c;
  logic [4:0]          lane_sh_c;
  logic [DATA_W-1:0]   rd_word_c, shifted_c, load_c, mask_c, merged_c;
  logic                unused_bits;

  // Misaligned or reserved-size requests are rejected without touching memory
  always_comb begin
    err_c = 1'b0;
    case (req_size)
      2'b00:   err_c = 1'b0;
      2'b01:   err_c = req_addr[0];
      2'b10:   err_c = (req_addr[1:0] != 2'b00);
      default: err_c = 1'b1;
    endcase
  end

  assign accept_c  = (state == IDLE) && req_valid;
  assign idx_c     = addr_q[ADDR_W-1:2];
  assign lane_sh_c = {addr_q[1:0], 3'b000};
  assign rd_word_c = mem[idx_c];

  // Load lane extraction; alignment is guaranteed, so one shift serves byte and half
  always_comb begin
    shifted_c = rd_word_c >> lane_sh_c;
    case (size_q)
      2'b00:   load_c = sign_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                               : {24'h0, shifted_c[7:0]};
      2'b01:   load_c = sign_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                               : {16'h0, shifted_c[15:0]};
      default: load_c = rd_word_c;
    endcase
  end

  // Store merge: new lane(s) over the old word captured in RD
  always_comb begin
    case (size_q)
      2'b00:   mask_c = DATA_W'(32'h0000_00FF) << lane_sh_c;
      2'b01:   mask_c = DATA_W'(32'h0000_FFFF) << lane_sh_c;
      default: mask_c = 32'hFFFF_FFFF;
    endcase
    merged_c = (word_q & ~mask_c) | ((wdata_q << lane_sh_c) & mask_c);
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next  = state;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    rsp_rdata_n = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (err_c) begin
            state_next  = RSP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end else begin
            state_next  = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_next  = WR;
        end else begin
          state_next  = RSP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = load_c;
        end
      end
      WR: begin
        state_next  = RSP;
        rsp_valid_n = 1'b1;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
      end
      RSP: begin
        if (rsp_ready) begin
          state_next  = IDLE;
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    req_ready_n = (state_next == IDLE);
  end

  // Request capture at acceptance; old word captured in RD for the merge
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      if (accept_c) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state == RD) begin
        word_q <= rd_word_c;
      end
    end
  end

  // Storage; reset clear wins over a pending write
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (state == WR) begin
      mem[idx_c] <= merged_c;
    end
  end

`ifdef DMEM_WRITE_LOG_EN
  logic [DATA_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (accept_c) begin
      pc_q <= req_pc;
    end
  end

  // One log line per committed write
  always_ff @(posedge clk) begin
    if (reset && (state == WR)) begin
      $display("@%h: *%h <= %h", pc_q, {20'h0, idx_c, 2'b00}, merged_c);
    end
  end

  assign unused_bits = ^req_addr[DATA_W-1:ADDR_W];
`else
  assign unused_bits = ^{req_addr[DATA_W-1:ADDR_W], req_pc};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a vector table driven through a
// request task, a scoreboard queue for responses, and hand-written
// sequences for backpressure and reset during a store.

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall the response,
  // then pop the scoreboard and compare at the response handshake.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = 32'h0000_1000 + addr;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    if (!rsp_valid) return;
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(e.err));
      if (h == 1) begin
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h60;
        req_wdata = 32'h5555_AAAA;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 3};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0, 3};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0022, 32'h0000_00AA, 32'h0,         1'b0, 3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'h11AA_3344, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0022, 32'h0,         32'hFFFF_FFAA, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_00AA, 1'b0, 2};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0032, 32'h0000_8001, 32'h0,         1'b0, 3};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0,         32'h8001_0000, 1'b0, 2};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0032, 32'h0,         32'hFFFF_8001, 1'b0, 2};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0041, 32'h0,         32'h0,         1'b1, 1};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0042, 32'h1234_5678, 32'h0,         1'b1, 1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b0, 2};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 1};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[15] = '{1'b1, 2'd0, 1'b0, 32'hFFFF_F013, 32'h0000_01FF, 32'h0,         1'b0, 3};
    vecs[16] = '{1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_FFAD, 1'b0, 2};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_pc    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);

    for (int i = 0; i < 17; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sign,
              vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].lat, 0);
    end

    // Full word at 0x10 after the upper-lane byte store
    run_req("word10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hFFAD_BEEF, 1'b0, 2, 0);

    // Backpressure: response held 5 cycles, a store pulse in between is dropped
    run_req("bp", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h11AA_3344, 1'b0, 2, 5);
    run_req("bp_drop", 1'b0, 2'd2, 1'b0, 32'h60, 32'h0, 32'h0, 1'b0, 2, 0);

    // Reset while a store sits in RD: no response, memory cleared
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_sign  = 1'b0;
    req_addr  = 32'h50;
    req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_rd_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("mid_ready_after", 32'(req_ready), 32'd1);
    run_req("mid_load50", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 2, 0);
    run_req("mid_load10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
